// File: rtl/window_pkg.sv
// rtl/window_pkg.sv - shared widths and scroll arithmetic for the obstacle window queue
package window_pkg;
    localparam int V_TOT  = 525;
    localparam int P_NUM  = 4;
    localparam int G_W    = 8;
    localparam int SPD_W  = 4;
    localparam int V_SIZE = $clog2(V_TOT);
    localparam int CNT_W  = $clog2(P_NUM + 1);

    // Scrolling clamps at the left edge instead of wrapping to a large x.
    function automatic logic [V_SIZE-1:0] sat_sub(input logic [V_SIZE-1:0] pos,
                                                  input logic [SPD_W-1:0]  spd);
        logic [V_SIZE-1:0] spd_ext;
        spd_ext = V_SIZE'(spd);
        return (pos > spd_ext) ? pos - spd_ext : '0;
    endfunction
endpackage

// File: rtl/window_slot.sv
// rtl/window_slot.sv - one queue slot holding x position, gap height and live flag
module window_slot
    import window_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              tick,
    input  logic [SPD_W-1:0]  speed,
    input  logic              load,
    input  logic [V_SIZE-1:0] load_pos,
    input  logic [G_W-1:0]    load_gap,
    input  logic              shift,
    input  logic [V_SIZE-1:0] shift_pos,
    input  logic [G_W-1:0]    shift_gap,
    input  logic              shift_valid,
    output logic [V_SIZE-1:0] pos,
    output logic [G_W-1:0]    gap,
    output logic              valid,
    output logic [V_SIZE-1:0] scrolled_pos
);
    // Post-tick position, also offered to the lower neighbour when the head retires.
    assign scrolled_pos = (tick && valid) ? sat_sub(pos, speed) : pos;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos   <= '0;
            gap   <= '0;
            valid <= 1'b0;
        end else if (clear) begin
            pos   <= '0;
            gap   <= '0;
            valid <= 1'b0;
        end else if (load) begin
            pos   <= load_pos;
            gap   <= load_gap;
            valid <= 1'b1;
        end else if (shift) begin
            pos   <= shift_pos;
            gap   <= shift_gap;
            valid <= shift_valid;
        end else begin
            pos   <= scrolled_pos;
        end
    end
endmodule

// File: rtl/window_queue.sv
// rtl/window_queue.sv - scrolling ordered queue of obstacle windows with retire, push and overflow
module window_queue
    import window_pkg::*;
(
    input  logic                    iClk,
    input  logic                    iRst_n,
    input  logic                    iClear,
    input  logic                    iTick,
    input  logic [SPD_W-1:0]        iSpeed,
    input  logic                    iPush,
    input  logic [V_SIZE-1:0]       iValue,
    input  logic [G_W-1:0]          iGap,
    output logic [P_NUM*V_SIZE-1:0] oWindowsPos,
    output logic [P_NUM*G_W-1:0]    oWindowsGap,
    output logic [P_NUM-1:0]        oValid,
    output logic [CNT_W-1:0]        oCount,
    output logic                    oFull,
    output logic                    oEmpty,
    output logic                    oRetire,
    output logic                    oOverflow
);
    logic [P_NUM-1:0][V_SIZE-1:0] pos;
    logic [P_NUM-1:0][V_SIZE-1:0] scrolled;
    logic [P_NUM-1:0][G_W-1:0]    gap;
    logic [P_NUM-1:0]             valid;
    logic [CNT_W-1:0]             count;
    logic [CNT_W-1:0]             cnt_after;
    logic [CNT_W-1:0]             count_next;
    logic                         retire;
    logic                         push_ok;
    logic                         overflow;

    // Retire happens before append, so a full queue can accept a push on a retiring tick.
    assign retire     = iTick && valid[0] && (scrolled[0] == '0);
    assign cnt_after  = count - CNT_W'(retire);
    assign push_ok    = iPush && (cnt_after != CNT_W'(P_NUM));
    assign overflow   = iPush && !push_ok;
    assign count_next = cnt_after + CNT_W'(push_ok);

    for (genvar k = 0; k < P_NUM; k++) begin : g_slot
        logic [V_SIZE-1:0] nb_pos;
        logic [G_W-1:0]    nb_gap;
        logic              nb_valid;

        if (k == P_NUM - 1) begin : g_tail
            assign nb_pos   = '0;
            assign nb_gap   = '0;
            assign nb_valid = 1'b0;
        end else begin : g_inner
            assign nb_pos   = scrolled[k+1];
            assign nb_gap   = gap[k+1];
            assign nb_valid = valid[k+1];
        end

        window_slot u_slot (
            .clk          (iClk),
            .rst_n        (iRst_n),
            .clear        (iClear),
            .tick         (iTick),
            .speed        (iSpeed),
            .load         (push_ok && (cnt_after == CNT_W'(k))),
            .load_pos     (iValue),
            .load_gap     (iGap),
            .shift        (retire),
            .shift_pos    (nb_pos),
            .shift_gap    (nb_gap),
            .shift_valid  (nb_valid),
            .pos          (pos[k]),
            .gap          (gap[k]),
            .valid        (valid[k]),
            .scrolled_pos (scrolled[k])
        );
    end

    assign oWindowsPos = pos;
    assign oWindowsGap = gap;
    assign oValid      = valid;
    assign oCount      = count;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            count     <= '0;
            oFull     <= 1'b0;
            oEmpty    <= 1'b1;
            oRetire   <= 1'b0;
            oOverflow <= 1'b0;
        end else if (iClear) begin
            count     <= '0;
            oFull     <= 1'b0;
            oEmpty    <= 1'b1;
            oRetire   <= 1'b0;
            oOverflow <= 1'b0;
        end else begin
            count     <= count_next;
            oFull     <= (count_next == CNT_W'(P_NUM));
            oEmpty    <= (count_next == '0);
            oRetire   <= retire;
            oOverflow <= overflow;
        end
    end
endmodule

// File: tb/tb_window_queue.sv
// tb/tb_window_queue.sv - randomized and directed checks of window_queue against a queue model
module tb_window_queue;
    import window_pkg::*;

    logic                    iClk;
    logic                    iRst_n;
    logic                    iClear;
    logic                    iTick;
    logic [SPD_W-1:0]        iSpeed;
    logic                    iPush;
    logic [V_SIZE-1:0]       iValue;
    logic [G_W-1:0]          iGap;
    logic [P_NUM*V_SIZE-1:0] oWindowsPos;
    logic [P_NUM*G_W-1:0]    oWindowsGap;
    logic [P_NUM-1:0]        oValid;
    logic [CNT_W-1:0]        oCount;
    logic                    oFull;
    logic                    oEmpty;
    logic                    oRetire;
    logic                    oOverflow;

    int n_checks = 0;
    int n_fail   = 0;

    int mq_pos[$];
    int mq_gap[$];
    bit exp_retire;
    bit exp_ovf;

    window_queue dut (
        .iClk        (iClk),
        .iRst_n      (iRst_n),
        .iClear      (iClear),
        .iTick       (iTick),
        .iSpeed      (iSpeed),
        .iPush       (iPush),
        .iValue      (iValue),
        .iGap        (iGap),
        .oWindowsPos (oWindowsPos),
        .oWindowsGap (oWindowsGap),
        .oValid      (oValid),
        .oCount      (oCount),
        .oFull       (oFull),
        .oEmpty      (oEmpty),
        .oRetire     (oRetire),
        .oOverflow   (oOverflow)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Queue semantics: scroll with clamp, retire at most one head at 0, then append if room.
    task automatic model_step(input bit clr, input bit tck, input int spd,
                              input bit psh, input int val, input int gp);
        exp_retire = 1'b0;
        exp_ovf    = 1'b0;
        if (clr) begin
            mq_pos.delete();
            mq_gap.delete();
            return;
        end
        if (tck) begin
            foreach (mq_pos[i]) mq_pos[i] = (mq_pos[i] > spd) ? mq_pos[i] - spd : 0;
            if (mq_pos.size() > 0 && mq_pos[0] == 0) begin
                void'(mq_pos.pop_front());
                void'(mq_gap.pop_front());
                exp_retire = 1'b1;
            end
        end
        if (psh) begin
            if (mq_pos.size() < P_NUM) begin
                mq_pos.push_back(val);
                mq_gap.push_back(gp);
            end else begin
                exp_ovf = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        logic [P_NUM*V_SIZE-1:0] ep;
        logic [P_NUM*G_W-1:0]    eg;
        logic [P_NUM-1:0]        ev;
        ep = '0;
        eg = '0;
        ev = '0;
        for (int k = 0; k < mq_pos.size(); k++) begin
            ep[k*V_SIZE +: V_SIZE] = V_SIZE'(mq_pos[k]);
            eg[k*G_W +: G_W]       = G_W'(mq_gap[k]);
            ev[k]                  = 1'b1;
        end
        check("pos",      64'(oWindowsPos), 64'(ep));
        check("gap",      64'(oWindowsGap), 64'(eg));
        check("valid",    64'(oValid),      64'(ev));
        check("count",    64'(oCount),      64'(mq_pos.size()));
        check("full",     64'(oFull),       64'(mq_pos.size() == P_NUM));
        check("empty",    64'(oEmpty),      64'(mq_pos.size() == 0));
        check("retire",   64'(oRetire),     64'(exp_retire));
        check("overflow", 64'(oOverflow),   64'(exp_ovf));
    endtask

    task automatic step(input bit clr, input bit tck, input int spd,
                        input bit psh, input int val, input int gp);
        iClear = clr;
        iTick  = tck;
        iSpeed = SPD_W'(spd);
        iPush  = psh;
        iValue = V_SIZE'(val);
        iGap   = G_W'(gp);
        @(posedge iClk);
        #1;
        model_step(clr, tck, spd, psh, val, gp);
        compare_all();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pos"},   64'(oWindowsPos), 64'd0);
        check({tag, "_gap"},   64'(oWindowsGap), 64'd0);
        check({tag, "_valid"}, 64'(oValid),      64'd0);
        check({tag, "_count"}, 64'(oCount),      64'd0);
        check({tag, "_empty"}, 64'(oEmpty),      64'd1);
        check({tag, "_full"},  64'(oFull),       64'd0);
        check({tag, "_pulse"}, 64'({oRetire, oOverflow}), 64'd0);
    endtask

    initial begin
        iRst_n = 1'b0;
        iClear = 1'b0;
        iTick  = 1'b0;
        iSpeed = '0;
        iPush  = 1'b0;
        iValue = '0;
        iGap   = '0;
        #12;
        check_reset_state("rst");
        @(negedge iClk);
        iRst_n = 1'b1;

        // Fill and overflow
        step(0, 0, 0, 1, 100, 50);
        step(0, 0, 0, 1, 200, 50);
        step(0, 0, 0, 1, 300, 50);
        step(0, 0, 0, 1, 400, 50);
        check("fill_count", 64'(oCount), 64'd4);
        check("fill_valid", 64'(oValid), 64'hF);
        check("fill_head",  64'(oWindowsPos[V_SIZE-1:0]), 64'd100);
        step(0, 0, 0, 1, 500, 50);
        check("ovf_pulse", 64'(oOverflow), 64'd1);
        check("ovf_tail",  64'(oWindowsPos[3*V_SIZE +: V_SIZE]), 64'd400);
        step(0, 0, 0, 0, 0, 0);
        check("ovf_once", 64'(oOverflow), 64'd0);

        // Saturating head retire
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 3, 1);
        step(0, 0, 0, 1, 20, 2);
        step(0, 0, 0, 1, 30, 3);
        step(0, 0, 0, 1, 40, 4);
        step(0, 1, 4, 0, 0, 0);
        check("sat_retire", 64'(oRetire), 64'd1);
        check("sat_head",   64'(oWindowsPos[V_SIZE-1:0]), 64'd16);
        check("sat_count",  64'(oCount), 64'd3);

        // Tick and push while full with a retiring head
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 2, 9);
        step(0, 0, 0, 1, 10, 9);
        step(0, 0, 0, 1, 11, 9);
        step(0, 0, 0, 1, 12, 9);
        step(0, 1, 2, 1, 77, 7);
        check("tp_count", 64'(oCount), 64'd4);
        check("tp_tail",  64'(oWindowsPos[3*V_SIZE +: V_SIZE]), 64'd77);
        check("tp_ovf",   64'(oOverflow), 64'd0);

        // Speed zero only retires a head already at 0
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 5);
        step(0, 0, 0, 1, 0, 6);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        check("spd0_empty", 64'(oEmpty), 64'd1);

        // Clear beats tick and push
        step(0, 0, 0, 1, 600, 1);
        step(1, 1, 5, 1, 33, 2);
        check("clr_count", 64'(oCount), 64'd0);
        step(0, 0, 0, 1, 55, 3);
        check("clr_next_head", 64'(oWindowsPos[V_SIZE-1:0]), 64'd55);

        // Asynchronous reset mid-run with three live slots
        step(0, 0, 0, 1, 70, 4);
        step(0, 0, 0, 1, 80, 5);
        #2;
        iRst_n = 1'b0;
        #1;
        check_reset_state("async");
        mq_pos.delete();
        mq_gap.delete();
        @(negedge iClk);
        iRst_n = 1'b1;

        for (int n = 0; n < 600; n++) begin
            bit clr;
            bit tck;
            bit psh;
            int spd;
            int val;
            clr = ($urandom_range(0, 49) == 0);
            tck = $urandom_range(0, 1) == 1;
            psh = $urandom_range(0, 1) == 1;
            spd = $urandom_range(0, 15);
            val = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 40);
            step(clr, tck, spd, psh, val, $urandom_range(0, 255));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
